// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issuer: opcode encoding and issuer FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_NOP = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StResp  = 2'b10
  } issuer_state_e;

endpackage

// File: rtl/alu_op_issuer.sv
// Sequences one command at a time into the combinational ALU and returns the registered
// result with a sequence tag.
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_opcode,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  input  logic                  cmd_chain,
  output logic [DATA_WIDTH-1:0] alu_operand_a,
  output logic [DATA_WIDTH-1:0] alu_operand_b,
  output logic [2:0]            alu_opcode,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_carry,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_carry,
  output logic                  rsp_err,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic [15:0]           ops_done
);

  issuer_state_e         state_q, state_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  opcode_e               opcode_q, opcode_d;
  logic [DATA_WIDTH-1:0] last_result_q, last_result_d;
  logic [TAG_WIDTH-1:0]  tag_cnt_q, tag_cnt_d;
  logic [TAG_WIDTH-1:0]  issue_tag_q, issue_tag_d;
  logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic                  rsp_zero_q, rsp_zero_d;
  logic                  rsp_carry_q, rsp_carry_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [TAG_WIDTH-1:0]  rsp_tag_q, rsp_tag_d;
  logic [15:0]           ops_done_q, ops_done_d;

  always_comb begin
    state_d       = state_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    opcode_d      = opcode_q;
    last_result_d = last_result_q;
    tag_cnt_d     = tag_cnt_q;
    issue_tag_d   = issue_tag_q;
    rsp_result_d  = rsp_result_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_carry_d   = rsp_carry_q;
    rsp_err_d     = rsp_err_q;
    rsp_tag_d     = rsp_tag_q;
    ops_done_d    = ops_done_q;

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_a_d      = cmd_chain ? last_result_q : cmd_a;
          op_b_d      = cmd_b;
          opcode_d    = opcode_e'(cmd_opcode);
          issue_tag_d = tag_cnt_q;
          tag_cnt_d   = tag_cnt_q + 1'b1;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        rsp_result_d  = alu_result;
        rsp_zero_d    = alu_zero;
        // ALU carry is the raw adder carry; only meaningful for ADD.
        rsp_carry_d   = alu_carry & (opcode_q == OP_ADD);
        rsp_err_d     = (opcode_q == OP_NOP);
        rsp_tag_d     = issue_tag_q;
        last_result_d = alu_result;
        state_d       = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
          if (ops_done_q != 16'hFFFF) begin
            ops_done_d = ops_done_q + 16'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      op_a_q        <= '0;
      op_b_q        <= '0;
      opcode_q      <= OP_ADD;
      last_result_q <= '0;
      tag_cnt_q     <= '0;
      issue_tag_q   <= '0;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_carry_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_tag_q     <= '0;
      ops_done_q    <= '0;
    end else begin
      state_q       <= state_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      opcode_q      <= opcode_d;
      last_result_q <= last_result_d;
      tag_cnt_q     <= tag_cnt_d;
      issue_tag_q   <= issue_tag_d;
      rsp_result_q  <= rsp_result_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_carry_q   <= rsp_carry_d;
      rsp_err_q     <= rsp_err_d;
      rsp_tag_q     <= rsp_tag_d;
      ops_done_q    <= ops_done_d;
    end
  end

  assign cmd_ready     = (state_q == StIdle);
  assign rsp_valid     = (state_q == StResp);
  assign alu_operand_a = op_a_q;
  assign alu_operand_b = op_b_q;
  assign alu_opcode    = opcode_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_zero      = rsp_zero_q;
  assign rsp_carry     = rsp_carry_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_tag       = rsp_tag_q;
  assign ops_done      = ops_done_q;

endmodule
